// File: rtl/lsu_pkg.sv
// Shared widths, default latencies and the store-buffer entry type for the load/store unit.
package lsu_pkg;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned TAG_W      = 6;
  localparam int unsigned LD_LATENCY = 4;
  localparam int unsigned WR_LATENCY = 3;
  localparam int unsigned SB_DEPTH   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } store_entry_t;
endpackage

// File: rtl/lsu_if.sv
// Request, memory-port and CDB signals of the load/store unit; slave is the LSU side.
interface lsu_if #(
  parameter int unsigned TAG_W = lsu_pkg::TAG_W
);
  import lsu_pkg::ADDR_W;
  import lsu_pkg::DATA_W;

  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [TAG_W-1:0]  req_tag;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  modport master (
    output req_valid, req_is_store, req_addr, req_data, req_tag, mem_rdata,
    input  req_ready, mem_raddr, mem_wen, mem_waddr, mem_wdata, cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    input  req_valid, req_is_store, req_addr, req_data, req_tag, mem_rdata,
    output req_ready, mem_raddr, mem_wen, mem_waddr, mem_wdata, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/store_buffer.sv
// Committed-store FIFO; exposes every entry oldest-first with a per-entry valid for forwarding.
module store_buffer
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  store_entry_t     i_push_entry,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output store_entry_t     o_head,
  output store_entry_t     o_entries [DEPTH],
  output logic [DEPTH-1:0] o_valid
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  store_entry_t     r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_head];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Index k is the k-th oldest entry, so a higher index is always a younger store
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      o_entries[k] = r_mem[r_head + PTR_W'(k)];
      o_valid[k]   = ((PTR_W+1)'(k) < r_count);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_tail] <= i_push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + 1'b1;
      if (w_do_pop)  r_head <= r_head + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/load_store_unit.sv
// In-order load/store unit: store buffer with forwarding, fixed-latency load pipeline, CDB broadcast.
module load_store_unit #(
  parameter int unsigned LD_LATENCY = lsu_pkg::LD_LATENCY,
  parameter int unsigned WR_LATENCY = lsu_pkg::WR_LATENCY,
  parameter int unsigned SB_DEPTH   = lsu_pkg::SB_DEPTH,
  parameter int unsigned TAG_W      = lsu_pkg::TAG_W
) (
  input  logic clk,
  input  logic reset,
  lsu_if.slave bus
);
  import lsu_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
  } load_stage_t;

  typedef struct packed {
    logic         valid;
    store_entry_t entry;
  } wr_slot_t;

  load_stage_t       r_ld_pipe [LD_LATENCY];
  wr_slot_t          r_wr_slot [WR_LATENCY];
  logic [ADDR_W-1:0] r_raddr;

  logic              w_sb_full;
  logic              w_sb_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_ld_accept;
  logic              w_block;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  store_entry_t      w_head;
  store_entry_t      w_push_entry;
  store_entry_t      w_sb_entries [SB_DEPTH];
  logic [SB_DEPTH-1:0] w_sb_valid;
  load_stage_t       w_ld_out;

  assign bus.req_ready = !(bus.req_is_store && w_sb_full);
  assign w_ld_accept   = !reset && bus.req_valid && !bus.req_is_store;
  assign w_push        = !reset && bus.req_valid && bus.req_is_store && !w_sb_full;
  assign w_push_entry  = '{addr: bus.req_addr, data: bus.req_data};
  assign w_pop         = !reset && !w_sb_empty && !w_block;

  store_buffer #(
    .DEPTH(SB_DEPTH)
  ) u_store_buffer (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_full       (w_sb_full),
    .o_empty      (w_sb_empty),
    .o_head       (w_head),
    .o_entries    (w_sb_entries),
    .o_valid      (w_sb_valid)
  );

  // A load that will read memory must sample before a same-address store is released
  always_comb begin
    w_block = 1'b0;
    for (int unsigned i = 0; i < LD_LATENCY; i++) begin
      if (r_ld_pipe[i].valid && !r_ld_pipe[i].fwd_hit && (r_ld_pipe[i].addr == w_head.addr))
        w_block = 1'b1;
    end
  end

  // Scan oldest in-flight write to youngest buffered store; the last match wins.
  // The head being drained this cycle is still a valid buffer entry, so it is covered here.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int unsigned i = WR_LATENCY; i > 0; i--) begin
      if (r_wr_slot[i-1].valid && (r_wr_slot[i-1].entry.addr == bus.req_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wr_slot[i-1].entry.data;
      end
    end
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      if (w_sb_valid[k] && (w_sb_entries[k].addr == bus.req_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_sb_entries[k].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LD_LATENCY; i++) r_ld_pipe[i] <= '0;
      for (int unsigned i = 0; i < WR_LATENCY; i++) r_wr_slot[i] <= '0;
      r_raddr <= '0;
    end else begin
      r_ld_pipe[0] <= '{valid: w_ld_accept, tag: bus.req_tag, addr: bus.req_addr,
                        fwd_hit: w_fwd_hit, fwd_data: w_fwd_data};
      for (int unsigned i = 1; i < LD_LATENCY; i++) r_ld_pipe[i] <= r_ld_pipe[i-1];
      r_wr_slot[0] <= '{valid: w_pop, entry: w_head};
      for (int unsigned i = 1; i < WR_LATENCY; i++) r_wr_slot[i] <= r_wr_slot[i-1];
      if (w_ld_accept) r_raddr <= bus.req_addr;
    end
  end

  assign w_ld_out      = r_ld_pipe[LD_LATENCY-1];
  assign bus.mem_raddr = reset ? '0 : (w_ld_accept ? bus.req_addr : r_raddr);
  assign bus.mem_wen   = w_pop;
  assign bus.mem_waddr = w_pop ? w_head.addr : '0;
  assign bus.mem_wdata = w_pop ? w_head.data : '0;
  assign bus.cdb_valid = !reset && w_ld_out.valid;
  assign bus.cdb_tag   = bus.cdb_valid ? w_ld_out.tag : '0;
  assign bus.cdb_data  = !bus.cdb_valid ? '0 :
                         (w_ld_out.fwd_hit ? w_ld_out.fwd_data : bus.mem_rdata);
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter LD_LATENCY, default 4, cycles from mem_raddr drive to valid mem_rdata.
REQ-002 Parameter WR_LATENCY, default 3, cycles from mem_wen pulse until the write is visible to a new read.
REQ-003 Parameter SB_DEPTH, default 4, store-buffer entries (power of two).
REQ-004 Parameter TAG_W, default 6, ROB tag width.
REQ-005 clk  in  1  sole clock; all state updates on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request offered this cycle.
REQ-008 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-009 req_is_store  in  1  1 = committed store, 0 = load.
REQ-010 req_addr  in  15  word address [15:1].
REQ-011 req_data  in  16  store data, ignored for loads.
REQ-012 req_tag  in  TAG_W  ROB tag of a load, ignored for stores.
REQ-013 mem_raddr  out  15  read address to memory data port.
REQ-014 mem_rdata  in  16  read data from memory, valid LD_LATENCY cycles after address.
REQ-015 mem_wen / mem_waddr / mem_wdata  out  1/15/16  memory write port.
REQ-016 cdb_valid / cdb_tag / cdb_data  out  1/TAG_W/16  load result broadcast.

Function
REQ-017 Requests arrive in program order; at most one per cycle.
REQ-018 req_ready = !(req_is_store && sb_full); loads are always accepted.
REQ-019 Accepted store enters store-buffer FIFO tail; it produces no CDB output.
REQ-020 Accepted load drives mem_raddr = req_addr in the same cycle and enters a LD_LATENCY-stage shift pipeline carrying {valid, tag, addr, fwd_hit, fwd_data}.
REQ-021 With no load accepted, mem_raddr holds its last value; memory reads have no side effect.
REQ-022 Forwarding: at acceptance, load compares its address against all valid store-buffer entries and all in-flight writes (WR_LATENCY window); the youngest match sets fwd_hit=1, fwd_data=its data.
REQ-023 A store draining in the acceptance cycle counts as in-flight for REQ-022.
REQ-024 cdb_valid asserts exactly LD_LATENCY cycles after load acceptance for one cycle, cdb_tag = load tag, cdb_data = fwd_hit ? fwd_data : mem_rdata.
REQ-025 Back-to-back loads produce back-to-back CDB results in acceptance order.
REQ-026 Drain: when the buffer is non-empty, its head is popped and driven on mem_wen=1, mem_waddr, mem_wdata in that cycle, unless REQ-027 blocks it.
REQ-027 Drain is blocked while any valid, non-forwarded in-flight load has the head's address (prevents a younger store overwriting before the load samples).
REQ-028 Each drained store occupies an in-flight-write slot for WR_LATENCY cycles, then retires.
REQ-029 Full buffer with drain in the same cycle: req_ready stays 0 (no push-while-pop at full).
REQ-030 Empty buffer with store push: the store becomes drainable next cycle, not same cycle.
REQ-031 FIFO pointers wrap modulo SB_DEPTH; full/empty are distinguished by a count or extra pointer bit.

Reset
REQ-032 In the cycle reset is high: store buffer emptied, in-flight writes and load pipeline invalidated; cdb_valid=0, mem_wen=0, mem_raddr=0, mem_waddr=0, mem_wdata=0, cdb_tag=0, cdb_data=0.
REQ-033 req_ready=1 from the first cycle after reset; loads in flight at reset never appear on the CDB.

Structure
REQ-034 Package lsu_pkg holds ADDR_W=15, DATA_W=16, TAG_W, LD_LATENCY, WR_LATENCY and the store-entry struct {addr, data}.
REQ-035 One sub-module, store_buffer: parameterised FIFO exposing push, pop, full, empty, head and all entries with per-entry valid for forwarding.

Verification
REQ-036 Load addr 0x0010, tag 5, memory holds 0xBEEF -> cdb_valid exactly 4 cycles later, tag 5, data 0xBEEF.
REQ-037 Store 0x0020<-0x1234, next cycle load 0x0020 tag 3 -> cdb_data 0x1234, with memory still holding its old value.
REQ-038 Stores 0x0030<-0xAAAA then 0x0030<-0xBBBB, then load 0x0030 -> cdb_data 0xBBBB (youngest wins).
REQ-039 Load 0x0040 issued, then store 0x0040<-0x5555 -> load returns old value; mem_wen for 0x0040 occurs no earlier than the load's CDB cycle.
REQ-040 Five stores with drain blocked by REQ-027 -> req_ready=0 on the fifth until a pop; no store lost; writes reach memory in order.
REQ-041 Reset asserted two cycles after a load -> no cdb_valid from that load; req_ready=1 the cycle after reset.
